multi_block_controller: RTL and testbench

Parametrised successor of the single-block VGA sprite controller. Holds NUM_BLOCKS independently positioned square blocks and moves the currently selected one with the direction buttons on each frame-rate tick. Edge behaviour is selectable: wrap-around or clamp. Sits between the button debouncers / tick generator and the VGA display_controller; it consumes hCount/vCount/bright and produces per-pixel rgb.

---
 rtl/multi_block_controller.sv | 117 +++++++++++
 tb/tb_multi_block_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multi_block_controller.sv
// Holds NUM_BLOCKS square sprites, moves the selected one on each move_tick (wrap or clamp at
// the visible edges) and produces the per-pixel colour for the VGA display controller.
module multi_block_controller #(
  parameter int NUM_BLOCKS = 4,
  parameter int HALF       = 5,
  parameter int STEP       = 2,
  parameter int H_MIN      = 144,
  parameter int H_MAX      = 783,
  parameter int V_MIN      = 35,
  parameter int V_MAX      = 515,
  parameter int WRAP       = 1,
  parameter logic [12*NUM_BLOCKS-1:0] COLORS = 48'hF0F_00F_0F0_F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_tick,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        sel,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [11:0] rgb,
  output logic [11:0] background,
  output logic [2:0]  active_idx
);

  localparam logic [10:0] XLO    = 11'(H_MIN + HALF);
  localparam logic [10:0] XHI    = 11'(H_MAX - HALF);
  localparam logic [10:0] YLO    = 11'(V_MIN + HALF);
  localparam logic [10:0] YHI    = 11'(V_MAX - HALF);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] HALF11 = 11'(HALF);

  logic [10:0]           r_x [NUM_BLOCKS];
  logic [10:0]           r_y [NUM_BLOCKS];
  logic                  r_sel_d;
  logic [2:0]            r_active_idx;
  logic [11:0]           r_background;
  logic [NUM_BLOCKS-1:0] w_hit;
  logic [10:0]           w_h;
  logic [10:0]           w_v;
  logic [11:0]           w_rgb;

  // 11-bit arithmetic keeps x+STEP and x-STEP free of 10-bit wrap at the screen limits.
  function automatic logic [10:0] f_inc(input logic [10:0] v, input logic [10:0] lo,
                                        input logic [10:0] hi);
    if (v + STEP11 > hi) return (WRAP != 0) ? lo : hi;
    return v + STEP11;
  endfunction

  function automatic logic [10:0] f_dec(input logic [10:0] v, input logic [10:0] lo,
                                        input logic [10:0] hi);
    if (v < lo + STEP11) return (WRAP != 0) ? hi : lo;
    return v - STEP11;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_x[i] <= 11'(H_MIN + 4 * HALF * (i + 1));
        r_y[i] <= 11'((V_MIN + V_MAX) / 2);
      end
      r_active_idx <= 3'd0;
      r_sel_d      <= 1'b0;
    end else begin
      r_sel_d <= sel;
      if (sel && !r_sel_d)
        r_active_idx <= (r_active_idx == 3'(NUM_BLOCKS - 1)) ? 3'd0 : r_active_idx + 3'd1;
      // The move uses the index as it stands before any same-cycle select edge.
      if (move_tick) begin
        for (int i = 0; i < NUM_BLOCKS; i++) begin
          if (r_active_idx == 3'(i)) begin
            if (right)     r_x[i] <= f_inc(r_x[i], XLO, XHI);
            else if (left) r_x[i] <= f_dec(r_x[i], XLO, XHI);
            else if (up)   r_y[i] <= f_dec(r_y[i], YLO, YHI);
            else if (down) r_y[i] <= f_inc(r_y[i], YLO, YHI);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_background <= 12'hFFF;
    else if (right) r_background <= 12'hFF0;
    else if (left)  r_background <= 12'h0FF;
    else if (down)  r_background <= 12'h0F0;
    else if (up)    r_background <= 12'h00F;
  end

  always_comb begin
    w_h   = {1'b0, hCount};
    w_v   = {1'b0, vCount};
    w_hit = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      w_hit[i] = (w_h + HALF11 >= r_x[i]) && (w_h <= r_x[i] + HALF11) &&
                 (w_v + HALF11 >= r_y[i]) && (w_v <= r_y[i] + HALF11);
    end
  end

  // Scanning downwards lets the lowest-index hit block win.
  always_comb begin
    w_rgb = r_background;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (w_hit[i]) w_rgb = COLORS[12*i +: 12];
    end
    if (!bright) w_rgb = 12'h000;
  end

  assign rgb        = w_rgb;
  assign background = r_background;
  assign active_idx = r_active_idx;

endmodule

// File: tb/tb_multi_block_controller.sv
// Randomised bench: two controllers (wrap and clamp) share stimulus; a queue-based
// scoreboard compares every cycle against a plain-arithmetic model of the block positions.
module tb_multi_block_controller;
  localparam int NB = 4, HALF = 5, STEP = 2;
  localparam int H_MIN = 144, H_MAX = 783, V_MIN = 35, V_MAX = 515;
  localparam int XLO = H_MIN + HALF, XHI = H_MAX - HALF;
  localparam int YLO = V_MIN + HALF, YHI = V_MAX - HALF;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst, move_tick, up, down, left, right, sel, bright;
  logic [9:0]  hCount, vCount;
  logic [11:0] rgb_w, rgb_c, bg_w, bg_c;
  logic [2:0]  idx_w, idx_c;

  logic [11:0] colors [NB] = '{12'hF00, 12'h0F0, 12'h00F, 12'hF0F};

  typedef struct packed {
    logic [11:0] rgb0;
    logic [11:0] rgb1;
    logic [11:0] bg;
    logic [2:0]  idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   driver_done = 1'b0;

  // Model state: index 0 is the wrapping instance, index 1 the clamping one.
  int          mx [2][NB];
  int          my [2][NB];
  int          m_idx;
  logic [11:0] m_bg;
  bit          m_seld;

  always #5 clk = ~clk;

  multi_block_controller #(.NUM_BLOCKS(NB), .HALF(HALF), .STEP(STEP), .H_MIN(H_MIN),
    .H_MAX(H_MAX), .V_MIN(V_MIN), .V_MAX(V_MAX), .WRAP(1), .COLORS(48'hF0F_00F_0F0_F00))
  dut_wrap (.clk(clk), .rst(rst), .move_tick(move_tick), .up(up), .down(down), .left(left),
    .right(right), .sel(sel), .bright(bright), .hCount(hCount), .vCount(vCount),
    .rgb(rgb_w), .background(bg_w), .active_idx(idx_w));

  multi_block_controller #(.NUM_BLOCKS(NB), .HALF(HALF), .STEP(STEP), .H_MIN(H_MIN),
    .H_MAX(H_MAX), .V_MIN(V_MIN), .V_MAX(V_MAX), .WRAP(0), .COLORS(48'hF0F_00F_0F0_F00))
  dut_clamp (.clk(clk), .rst(rst), .move_tick(move_tick), .up(up), .down(down), .left(left),
    .right(right), .sel(sel), .bright(bright), .hCount(hCount), .vCount(vCount),
    .rgb(rgb_c), .background(bg_c), .active_idx(idx_c));

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < NB; i++) begin
        mx[w][i] = H_MIN + 4 * HALF * (i + 1);
        my[w][i] = (V_MIN + V_MAX) / 2;
      end
    m_idx  = 0;
    m_bg   = 12'hFFF;
    m_seld = 1'b0;
  endtask

  // Applies one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    int x, y;
    if (rst) begin
      model_reset();
      return;
    end
    if (move_tick) begin
      for (int w = 0; w < 2; w++) begin
        x = mx[w][m_idx];
        y = my[w][m_idx];
        if (right) begin
          x = x + STEP;
          if (x > XHI) x = (w == 0) ? XLO : XHI;
        end else if (left) begin
          x = x - STEP;
          if (x < XLO) x = (w == 0) ? XHI : XLO;
        end else if (up) begin
          y = y - STEP;
          if (y < YLO) y = (w == 0) ? YHI : YLO;
        end else if (down) begin
          y = y + STEP;
          if (y > YHI) y = (w == 0) ? YLO : YHI;
        end
        mx[w][m_idx] = x;
        my[w][m_idx] = y;
      end
    end
    if (right)     m_bg = 12'hFF0;
    else if (left) m_bg = 12'h0FF;
    else if (down) m_bg = 12'h0F0;
    else if (up)   m_bg = 12'h00F;
    if (sel && !m_seld) m_idx = (m_idx + 1) % NB;
    m_seld = sel;
  endtask

  function automatic logic [11:0] model_pix(input int w);
    int h, v;
    h = int'(hCount);
    v = int'(vCount);
    if (!bright) return 12'h000;
    for (int i = 0; i < NB; i++) begin
      if (h >= mx[w][i] - HALF && h <= mx[w][i] + HALF &&
          v >= my[w][i] - HALF && v <= my[w][i] + HALF)
        return colors[i];
    end
    return m_bg;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // Stimulus: phases bias the buttons so every edge of the play field gets hit.
  initial begin
    int b, r, ph;
    exp_t e;
    rst = 1'b1; move_tick = 0; up = 0; down = 0; left = 0; right = 0; sel = 0;
    bright = 1'b1; hCount = 10'd164; vCount = 10'd275;
    model_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      model_step();
      ph = c / 700;
      move_tick = ($urandom % 2) == 0;
      right = 0; left = 0; up = 0; down = 0; sel = 0;
      case (ph)
        0: begin right = 1; up = ($urandom % 8) == 0; left = ($urandom % 8) == 0; end
        1: begin up = 1; down = ($urandom % 8) == 0; end
        2: begin left = 1; sel = (c % 97) < 3; end
        3: begin down = 1; sel = (c % 131) < 5; end
        default: begin
          right = ($urandom % 3) == 0; left = ($urandom % 3) == 0;
          up = ($urandom % 3) == 0; down = ($urandom % 3) == 0;
          sel = ($urandom % 8) == 0;
        end
      endcase
      rst = (c < 3) || (ph >= 4 && ($urandom % 150) == 0);
      if (rst) model_reset();
      r = $urandom % 4;
      if (r == 0) begin
        hCount = 10'($urandom % 1024);
        vCount = 10'($urandom % 1024);
      end else begin
        b = $urandom % NB;
        hCount = 10'(mx[r % 2][b] + int'($urandom % (2 * HALF + 3)) - HALF - 1);
        vCount = 10'(my[r % 2][b] + int'($urandom % (2 * HALF + 3)) - HALF - 1);
      end
      bright = ($urandom % 8) != 0;
      e.rgb0 = model_pix(0);
      e.rgb1 = model_pix(1);
      e.bg   = m_bg;
      e.idx  = 3'(m_idx);
      q.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    driver_done = 1'b1;
  end

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    int   guard;
    guard = 0;
    while (!driver_done && guard < NCYC + 100) begin
      @(negedge clk);
      guard++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rgb_wrap",   rgb_w, e.rgb0);
        chk("rgb_clamp",  rgb_c, e.rgb1);
        chk("bg_wrap",    bg_w,  e.bg);
        chk("bg_clamp",   bg_c,  e.bg);
        chk("idx_wrap",   {9'd0, idx_w}, {9'd0, e.idx});
        chk("idx_clamp",  {9'd0, idx_c}, {9'd0, e.idx});
      end
    end
    chk("run_complete", {11'd0, driver_done}, 12'd1);
    chk("queue_drained", 12'(q.size()), 12'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
